mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one external SRAM-like bus between two requesters:
  - the instruction-fetch port;
  - the MEM-stage data port (ram_en / ram_write_en / ram_addr / ram_write_data).
- Sequences each access through address and data handshakes, with one outstanding transaction at a time.
- Returns read data to the requester and raises per-port stall requests to the pipeline controller.
- Supports pipeline flush: a flushed access is either dropped or drained.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- inst_en  in  1  fetch request, held until consumed
- inst_addr  in  ADDR_WIDTH  fetch address, word-aligned
- inst_consume  in  1  IF stage accepted inst_rdata this cycle
- inst_rdata  out  DATA_WIDTH  fetched word
- inst_valid  out  1  inst_rdata valid, level
- inst_stall  out  1  inst_en high and not inst_valid
- ram_en  in  1  data request, held until consumed
- ram_write_en  in  4  byte strobes; 0 means read
- ram_addr  in  ADDR_WIDTH  word-aligned data address
- ram_write_data  in  DATA_WIDTH  pre-shifted store data
- data_consume  in  1  MEM stage accepted the result this cycle
- ram_read_data  out  DATA_WIDTH  loaded word
- data_valid  out  1  data access complete (read or write), level
- data_stall  out  1  ram_en high and not data_valid
- flush  in  1  exception/ERET flush, 1-cycle pulse
- bus_req  out  1  address-phase request
- bus_wr  out  1  write when 1
- bus_wstrb  out  4  byte strobes
- bus_addr  out  ADDR_WIDTH  access address
- bus_wdata  out  DATA_WIDTH  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  read data or write completion
- bus_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset (rst low, async): FSM=IDLE; all out regs and flags 0; bus_req=0.
- FSM states:
  - IDLE
    - Grant: data wins over inst (older instruction).
    - A side is eligible when its en=1, its done flag=0 and flush=0.
    - On grant, latch owner, addr, wstrb, wdata and wr=|ram_write_en (inst: wr=0, wstrb=0); go ADDR.
    - bus_req rises the cycle after grant.
  - ADDR
    - bus_req=1; bus_addr/bus_wr/bus_wstrb/bus_wdata come from the latched registers and are stable.
    - On bus_addr_ok go WAIT; bus_req drops the next cycle.
    - A flush while bus_addr_ok=0: drop the request, bus_req=0 next cycle, go IDLE.
    - A flush together with bus_addr_ok: go WAIT with discard=1.
  - WAIT
    - On bus_data_ok: if discard=0, capture bus_rdata into the owner's rdata register (writes leave rdata unchanged) and set the owner's done flag.
    - Then go IDLE, clearing discard.
    - A flush in WAIT sets discard=1; the state must not leave WAIT before bus_data_ok.
- Latency: minimum 3 cycles from en to valid (grant → addr_ok → data_ok, with addr_ok and data_ok each in the first possible cycle).
- data_valid = data done flag. inst_valid = inst done flag.
- Each done flag clears on its consume=1, on its en=0, or on flush. Clear takes priority over a same-cycle set from a discarded response.
- A done side is not re-granted until its flag clears. A consume in the same cycle as IDLE arbitration does not make that side eligible until the next cycle.
- inst_stall / data_stall are combinational from en and the valid flags.
- bus_addr_ok and bus_data_ok in the same cycle while in ADDR: treat as addr_ok only. The bus never returns data_ok before addr_ok is registered.
- Requests arriving while busy wait; there is no queueing beyond the held en level.
- ram_write_en=4'b0000 with ram_en=1 is a read.

Decomposition:
- Shared package (bus defines): FSM state encoding (IDLE=2'd0, ADDR=2'd1, WAIT=2'd2), owner encoding (OWNER_INST=0, OWNER_DATA=1), and the bus width macros already used by MEM (`ADDR_BUS`, `DATA_BUS`).
- No sub-module needed. The fixed-priority grant logic is inline combinational code in the same file.

Test Plan:
- Inst fetch only:
  - stimulus: inst_en=1, addr=0xBFC00000; bus answers addr_ok cycle 2, data_ok cycle 3, rdata=0x3C080001
  - required: inst_valid=1 with inst_rdata=0x3C080001; inst_stall=0 from that cycle; one bus_req transaction.
- Simultaneous requests:
  - stimulus: inst_en and ram_en (read 0x80001000) in the same cycle
  - required: data transaction first, then inst; data_stall clears before inst_stall; exactly 2 bus transactions.
- Store:
  - stimulus: ram_en=1, ram_write_en=4'b1100, ram_addr=0x80000004, wdata=0xABCD0000
  - required: bus_wr=1, bus_wstrb=4'b1100, bus_wdata=0xABCD0000; data_valid after data_ok; ram_read_data unchanged.
- Held request without consume:
  - stimulus: ram_en held 5 cycles after data_valid, no data_consume
  - required: no second bus_req; data_consume pulse clears data_valid next cycle.
- Flush in ADDR:
  - stimulus: addr_ok withheld, flush pulse
  - required: bus_req=0 next cycle; FSM=IDLE; no valid asserted.
- Flush in WAIT, and reset mid-operation:
  - stimulus: flush pulse in WAIT, data_ok 4 cycles later
  - required: FSM stays WAIT until data_ok; result discarded (valid stays 0); next grant only after data_ok.
  - stimulus: rst low mid-WAIT
  - required: all outputs 0 immediately.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus widths, FSM state and owner encodings.
package mem_bus_arbiter_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / MEM data) arbiter onto a single SRAM-like bus with address and data handshakes.
// One transaction is outstanding at a time; flushed accesses are dropped or drained.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_en,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_consume,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_valid,
    output logic                  inst_stall,

    input  logic                  ram_en,
    input  logic [3:0]            ram_write_en,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic                  data_consume,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  data_valid,
    output logic                  data_stall,

    input  logic                  flush,

    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [3:0]            bus_wstrb,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    state_t                state, state_next;
    owner_t                owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic                  wr_q;
    logic                  discard;
    logic                  inst_done, data_done;

    logic data_eligible, inst_eligible, grant;
    logic response, inst_set, data_set, inst_clear, data_clear;

    // Fixed priority: the data port belongs to the older instruction, so it wins.
    assign data_eligible = ram_en  & ~data_done & ~flush;
    assign inst_eligible = inst_en & ~inst_done & ~flush;
    assign grant         = (state == IDLE) & (data_eligible | inst_eligible);

    assign response   = (state == WAIT) & bus_data_ok & ~discard;
    assign inst_set   = response & (owner == OWNER_INST);
    assign data_set   = response & (owner == OWNER_DATA);
    assign inst_clear = inst_consume | ~inst_en | flush;
    assign data_clear = data_consume | ~ram_en  | flush;

    always_comb begin
        // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = ADDR;
            ADDR: begin
                if (bus_addr_ok)  state_next = WAIT;
                else if (flush)   state_next = IDLE;
            end
            WAIT: if (bus_data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= OWNER_INST;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wr_q    <= 1'b0;
            discard <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner   <= data_eligible ? OWNER_DATA : OWNER_INST;
                addr_q  <= data_eligible ? ram_addr : inst_addr;
                wdata_q <= data_eligible ? ram_write_data : '0;
                wstrb_q <= data_eligible ? ram_write_en : 4'b0000;
                wr_q    <= data_eligible & (|ram_write_en);
            end
            // A response already in flight cannot be cancelled on the bus; mark it to be drained.
            case (state)
                ADDR: if (bus_addr_ok) discard <= flush;
                WAIT: begin
                    if (bus_data_ok) discard <= 1'b0;
                    else if (flush)  discard <= 1'b1;
                end
                default: discard <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_done     <= 1'b0;
            data_done     <= 1'b0;
            inst_rdata    <= '0;
            ram_read_data <= '0;
        end else begin
            if (inst_clear)    inst_done <= 1'b0;
            else if (inst_set) inst_done <= 1'b1;

            if (data_clear)    data_done <= 1'b0;
            else if (data_set) data_done <= 1'b1;

            if (inst_set)          inst_rdata    <= bus_rdata;
            if (data_set && !wr_q) ram_read_data <= bus_rdata;
        end
    end

    assign inst_valid = inst_done;
    assign data_valid = data_done;
    assign inst_stall = inst_en & ~inst_done;
    assign data_stall = ram_en  & ~data_done;

    assign bus_req   = (state == ADDR);
    assign bus_wr    = wr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a bus responder model, a valid-edge monitor and per-feature tests.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en, inst_consume, inst_valid, inst_stall;
    logic [31:0] inst_addr, inst_rdata;
    logic        ram_en, data_consume, data_valid, data_stall;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        flush;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_consume(inst_consume),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid), .inst_stall(inst_stall),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .data_consume(data_consume),
        .ram_read_data(ram_read_data), .data_valid(data_valid), .data_stall(data_stall),
        .flush(flush),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_data; bit chk; logic [31:0] rdata; } exp_t;
    typedef struct { logic [31:0] addr; logic wr; logic [3:0] wstrb; logic [31:0] wdata; } txn_t;

    exp_t        exp_q[$];
    txn_t        txn_q[$];
    int          total = 0;
    int          bad = 0;
    int          data_wait = 0;
    bit          withhold = 0;
    int          dok_count = 0;
    logic [31:0] ram_rdata_exp = 32'h0;

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Bus slave: addr_ok on the first bus_req cycle (unless withheld), data_ok after data_wait cycles.
    initial begin : responder
        int phase;
        int cnt;
        logic [31:0] pend;
        phase = 0; cnt = 0; pend = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rst !== 1'b1) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (bus_req === 1'b1 && !withhold) begin
                    bus_addr_ok = 1'b1;
                    txn_q.push_back('{addr: bus_addr, wr: bus_wr, wstrb: bus_wstrb, wdata: bus_wdata});
                    pend  = bus_word(bus_addr);
                    phase = 1; cnt = 0;
                end
            end else if (cnt >= data_wait) begin
                bus_data_ok = 1'b1;
                bus_rdata   = pend;
                dok_count++;
                phase = 0; cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    task automatic sb_pop(input bit is_data, input logic [31:0] rdata);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: port=%0d raised valid, no entry expected", is_data);
        end else begin
            e = exp_q.pop_front();
            if (e.is_data != is_data) begin
                bad++;
                $display("FAIL sb_order: got port=%0d want port=%0d", is_data, e.is_data);
            end else if (e.chk && rdata !== e.rdata) begin
                bad++;
                $display("FAIL sb_rdata: port=%0d got %h want %h", is_data, rdata, e.rdata);
            end
        end
    endtask

    // Each rising valid pops the next expected completion.
    initial begin : monitor
        bit prev_iv, prev_dv;
        prev_iv = 0; prev_dv = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (data_valid === 1'b1 && !prev_dv) sb_pop(1'b1, ram_read_data);
                if (inst_valid === 1'b1 && !prev_iv) sb_pop(1'b0, inst_rdata);
            end
            prev_dv = (data_valid === 1'b1);
            prev_iv = (inst_valid === 1'b1);
        end
    end

    task automatic wait_valid(input bit is_data, input int max_cycles, output int cycles);
        cycles = -1;
        for (int n = 1; n <= max_cycles; n++) begin
            @(negedge clk);
            if ((is_data ? data_valid : inst_valid) === 1'b1) begin
                cycles = n;
                return;
            end
        end
    endtask

    task automatic wait_state(input state_t s, input int max_cycles, output int cycles);
        cycles = -1;
        for (int n = 1; n <= max_cycles; n++) begin
            @(negedge clk);
            if (dut.state === s) begin
                cycles = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus_req !== 1'b0)     begin bad++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
        total++; if (inst_valid !== 1'b0)  begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        total++; if (data_valid !== 1'b0)  begin bad++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
        total++; if (inst_rdata !== 32'h0) begin bad++; $display("FAIL rst_inst_rdata: got %h want 0", inst_rdata); end
        total++; if (bus_addr !== 32'h0)   begin bad++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
        total++; if (dut.state !== IDLE)   begin bad++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_inst_fetch();
        int base, n;
        base = txn_q.size();
        inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
        exp_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: 32'h3C08_0001});
        #1;
        total++; if (inst_stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_on: got %b want 1", inst_stall); end
        wait_valid(1'b0, 20, n);
        total++; if (n != 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", n); end
        total++; if (inst_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_off: got %b want 0", inst_stall); end
        total++; if (inst_rdata !== 32'h3C08_0001) begin bad++; $display("FAIL fetch_rdata: got %h want 3c080001", inst_rdata); end
        inst_consume = 1'b1; inst_en = 1'b0;
        @(negedge clk);
        inst_consume = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fetch_consume: got %b want 0", inst_valid); end
        repeat (3) @(negedge clk);
        total++; if (txn_q.size() - base != 1) begin bad++; $display("FAIL fetch_txns: got %0d want 1", txn_q.size() - base); end
        total++; if (txn_q[base].addr !== 32'hBFC0_0000 || txn_q[base].wr !== 1'b0) begin
            bad++; $display("FAIL fetch_txn: got addr %h wr %b want bfc00000 0", txn_q[base].addr, txn_q[base].wr);
        end
    endtask

    task automatic test_simultaneous();
        int base, dcyc, icyc;
        base = txn_q.size();
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h8000_1000;
        inst_en = 1'b1; inst_addr = 32'hBFC0_0004;
        ram_rdata_exp = bus_word(32'h8000_1000);
        exp_q.push_back('{is_data: 1'b1, chk: 1'b1, rdata: ram_rdata_exp});
        exp_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: bus_word(32'hBFC0_0004)});
        dcyc = -1; icyc = -1;
        for (int n = 1; n <= 40 && (dcyc < 0 || icyc < 0); n++) begin
            @(negedge clk);
            data_consume = 1'b0; inst_consume = 1'b0;
            if (dcyc < 0 && data_stall === 1'b0) begin dcyc = n; data_consume = 1'b1; ram_en = 1'b0; end
            if (icyc < 0 && inst_stall === 1'b0) begin icyc = n; inst_consume = 1'b1; inst_en = 1'b0; end
        end
        @(negedge clk);
        data_consume = 1'b0; inst_consume = 1'b0;
        total++; if (dcyc != 3) begin bad++; $display("FAIL simul_data_cycle: got %0d want 3", dcyc); end
        total++; if (icyc != 6) begin bad++; $display("FAIL simul_inst_cycle: got %0d want 6", icyc); end
        repeat (2) @(negedge clk);
        total++; if (txn_q.size() - base != 2) begin bad++; $display("FAIL simul_txns: got %0d want 2", txn_q.size() - base); end
        total++; if (txn_q[base].addr !== 32'h8000_1000 || txn_q[base+1].addr !== 32'hBFC0_0004) begin
            bad++; $display("FAIL simul_order: got %h,%h want 80001000,bfc00004", txn_q[base].addr, txn_q[base+1].addr);
        end
    endtask

    task automatic test_store();
        int base, n;
        bit seen;
        base = txn_q.size();
        ram_en = 1'b1; ram_write_en = 4'b1100; ram_addr = 32'h8000_0004; ram_write_data = 32'hABCD_0000;
        exp_q.push_back('{is_data: 1'b1, chk: 1'b1, rdata: ram_rdata_exp});
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (bus_req === 1'b1);
        end
        total++; if (!seen) begin bad++; $display("FAIL store_req: got no bus_req want 1"); end
        total++; if (bus_wr !== 1'b1 || bus_wstrb !== 4'b1100) begin
            bad++; $display("FAIL store_ctrl: got wr %b wstrb %b want 1 1100", bus_wr, bus_wstrb);
        end
        total++; if (bus_wdata !== 32'hABCD_0000 || bus_addr !== 32'h8000_0004) begin
            bad++; $display("FAIL store_payload: got %h@%h want abcd0000@80000004", bus_wdata, bus_addr);
        end
        wait_valid(1'b1, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL store_valid: got timeout want data_valid"); end
        total++; if (ram_read_data !== ram_rdata_exp) begin
            bad++; $display("FAIL store_rdata_kept: got %h want %h", ram_read_data, ram_rdata_exp);
        end
    endtask

    task automatic test_held_no_consume();
        int base;
        base = txn_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (data_valid !== 1'b1 || bus_req !== 1'b0) begin
                bad++; $display("FAIL held_cycle%0d: got valid %b req %b want 1 0", i, data_valid, bus_req);
            end
        end
        data_consume = 1'b1;
        @(negedge clk);
        data_consume = 1'b0;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL held_consume: got %b want 0", data_valid); end
        ram_en = 1'b0; ram_write_en = 4'b0000;
        repeat (3) @(negedge clk);
        total++; if (txn_q.size() != base) begin bad++; $display("FAIL held_txns: got %0d want 0", txn_q.size() - base); end
    endtask

    task automatic test_flush_addr();
        int base, n;
        base = txn_q.size();
        withhold = 1;
        inst_en = 1'b1; inst_addr = 32'hBFC0_0008;
        wait_state(ADDR, 10, n);
        total++; if (n < 0) begin bad++; $display("FAIL flush_addr_enter: got timeout want ADDR"); end
        @(negedge clk);
        flush = 1'b1; inst_en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL flush_addr_req: got %b want 0", bus_req); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL flush_addr_state: got %0d want IDLE", dut.state); end
        withhold = 0;
        repeat (4) @(negedge clk);
        total++; if (inst_valid !== 1'b0 || txn_q.size() != base) begin
            bad++; $display("FAIL flush_addr_quiet: got valid %b txns %0d want 0 0", inst_valid, txn_q.size() - base);
        end
    endtask

    task automatic test_flush_wait();
        int base, n, dok0, waits;
        base = txn_q.size();
        data_wait = 4;
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h8000_2000;
        wait_state(WAIT, 10, n);
        total++; if (n < 0) begin bad++; $display("FAIL flush_wait_enter: got timeout want WAIT"); end
        dok0 = dok_count;
        flush = 1'b1; ram_en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        inst_en = 1'b1; inst_addr = 32'hBFC0_000C;
        exp_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: bus_word(32'hBFC0_000C)});
        waits = 0;
        for (int i = 0; i < 20 && dok_count == dok0; i++) begin
            total++; if (dut.state !== WAIT || bus_req !== 1'b0 || data_valid !== 1'b0) begin
                bad++; $display("FAIL flush_wait_hold: got state %0d req %b valid %b want WAIT 0 0", dut.state, bus_req, data_valid);
            end
            waits++;
            @(negedge clk);
        end
        data_wait = 0;
        total++; if (waits < 2) begin bad++; $display("FAIL flush_wait_span: got %0d want >=2", waits); end
        wait_valid(1'b0, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL flush_wait_next: got timeout want inst_valid"); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL flush_wait_discard: got %b want 0", data_valid); end
        total++; if (txn_q.size() - base != 2 || txn_q[base+1].addr !== 32'hBFC0_000C) begin
            bad++; $display("FAIL flush_wait_txns: got %0d want 2 ending bfc0000c", txn_q.size() - base);
        end
        inst_consume = 1'b1; inst_en = 1'b0;
        @(negedge clk);
        inst_consume = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        data_wait = 6;
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h8000_3000;
        wait_state(WAIT, 10, n);
        total++; if (n < 0) begin bad++; $display("FAIL rmid_enter: got timeout want WAIT"); end
        rst = 1'b0; ram_en = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wr !== 1'b0) begin
            bad++; $display("FAIL rmid_bus: got req %b addr %h wr %b want 0", bus_req, bus_addr, bus_wr);
        end
        total++; if (data_valid !== 1'b0 || inst_valid !== 1'b0 || data_stall !== 1'b0) begin
            bad++; $display("FAIL rmid_flags: got dv %b iv %b ds %b want 0", data_valid, inst_valid, data_stall);
        end
        ram_rdata_exp = 32'h0;
        total++; if (ram_read_data !== ram_rdata_exp || inst_rdata !== 32'h0) begin
            bad++; $display("FAIL rmid_rdata: got %h/%h want 0", ram_read_data, inst_rdata);
        end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rmid_state: got %0d want IDLE", dut.state); end
        repeat (2) @(negedge clk);
        rst = 1'b1; data_wait = 0;
        @(negedge clk);
        inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
        exp_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: 32'h3C08_0001});
        wait_valid(1'b0, 20, n);
        total++; if (n != 3) begin bad++; $display("FAIL rmid_recover: got %0d want 3", n); end
        inst_consume = 1'b1; inst_en = 1'b0;
        @(negedge clk);
        inst_consume = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        inst_en = 1'b0; inst_addr = '0; inst_consume = 1'b0;
        ram_en = 1'b0; ram_write_en = '0; ram_addr = '0; ram_write_data = '0; data_consume = 1'b0;
        flush = 1'b0;
        test_reset();
        test_inst_fetch();
        test_simultaneous();
        test_store();
        test_held_no_consume();
        test_flush_addr();
        test_flush_wait();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
